// File: rtl/csk_pkg.sv
// csk_pkg: shared constants and types for the carry-skip subtract pipeline.
// One slice of BLK_W bits is resolved per pipeline stage.
package csk_pkg;

  localparam int BLK_W = 4;

  typedef logic [BLK_W-1:0] nib_t;

  function automatic int num_blk(input int width);
    return width / BLK_W;
  endfunction

endpackage

// File: rtl/csk_sub_blk4.sv
// csk_sub_blk4: combinational 4-bit carry-skip slice computing a + b_n + cin.
// The skip mux forwards cin straight to cout when every bit propagates.
module csk_sub_blk4
  import csk_pkg::*;
(
  input  nib_t i_a,
  input  nib_t i_b_n,
  input  logic i_cin,
  output nib_t o_s,
  output logic o_cout
);

  nib_t             w_p;
  logic [BLK_W:0]   w_c;

  always_comb begin
    w_p    = i_a ^ i_b_n;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < BLK_W; i++) begin
      w_c[i+1] = (i_a[i] & i_b_n[i])
               | (w_p[i] & w_c[i]);
    end
  end

  assign o_s    = w_p ^ w_c[BLK_W-1:0];
  assign o_cout = (&w_p) ? i_cin : w_c[BLK_W];

endmodule

// File: rtl/csk_sub_pipe.sv
// csk_sub_pipe: pipelined a - b - bin, one carry-skip slice per stage.
// Define CSK_SUB_OVF_EN to add the signed-overflow output ovf.
module csk_sub_pipe
  import csk_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef CSK_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int NUM_BLK = num_blk(WIDTH);

  if ((WIDTH % BLK_W) != 0 || WIDTH < BLK_W) begin : g_chk
    $error("csk_sub_pipe: WIDTH must be a positive multiple of 4");
  end

  // b_hi holds the inverted subtrahend so each slice is a plain add.
  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] diff_lo;
`ifdef CSK_SUB_OVF_EN
    logic [1:0]       sgn;
`endif
  } stg_t;

  logic               w_adv;
  logic [NUM_BLK-1:0] w_vld;
  stg_t               w_q [NUM_BLK];
  stg_t               w_last;
  logic               w_unused;

  assign w_adv    = ~w_vld[NUM_BLK-1] | out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_stg
    logic w_vin;
    stg_t w_src;
    stg_t w_nxt;
    stg_t r_q;
    logic r_v;
    nib_t w_s;
    logic w_co;

    if (k == 0) begin : g_head
      assign w_vin = in_valid;
      always_comb begin
        w_src       = '0;
        w_src.carry = ~bin;
        w_src.a_hi  = a;
        w_src.b_hi  = ~b;
      end
    end else begin : g_body
      assign w_vin = w_vld[k-1];
      assign w_src = w_q[k-1];
    end

    csk_sub_blk4 u_blk (
      .i_a    (w_src.a_hi[k*BLK_W +: BLK_W]),
      .i_b_n  (w_src.b_hi[k*BLK_W +: BLK_W]),
      .i_cin  (w_src.carry),
      .o_s    (w_s),
      .o_cout (w_co)
    );

    always_comb begin
      w_nxt       = w_src;
      w_nxt.carry = w_co;
      w_nxt.diff_lo[k*BLK_W +: BLK_W] = w_s;
`ifdef CSK_SUB_OVF_EN
      w_nxt.sgn = {w_src.a_hi[WIDTH-1],
                   ~w_src.b_hi[WIDTH-1]};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_vin;
      end
    end

    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_q <= w_nxt;
      end
    end

    assign w_vld[k] = r_v;
    assign w_q[k]   = r_q;
  end

  assign w_last    = w_q[NUM_BLK-1];
  assign out_valid = w_vld[NUM_BLK-1];
  assign diff      = out_valid ? w_last.diff_lo : '0;
  assign bout      = out_valid & ~w_last.carry;

`ifdef CSK_SUB_OVF_EN
  assign ovf = out_valid
             & (w_last.sgn[1] ^ w_last.sgn[0])
             & (w_last.diff_lo[WIDTH-1] ^ w_last.sgn[1]);
`endif

  assign w_unused = ^{w_last.a_hi, w_last.b_hi};

endmodule
